ysyx_22050710_ctrl: RTL

Multi-cycle sequencing controller for the ysyx_22050710 RV64 core. It steps each instruction through fetch, decode, execute, memory and write-back phases. It holds the instruction register, PC and architectural-state write enables until the right phase, and handshakes with the IFU, LSU and multi-cycle mul/div unit. It also halts the core on ebreak, an invalid instruction, or a bus timeout.

---
 rtl/ysyx_22050710_ctrl_pkg.sv | 39 +++
 rtl/ysyx_22050710_ctrl_if.sv | 42 ++++
 rtl/ysyx_22050710_wait_timer.sv | 34 +++
 rtl/ysyx_22050710_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ysyx_22050710_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : ysyx_22050710_ctrl_pkg
// Brief    : State encoding, halt causes and decoder code points for the
//            multi-cycle sequencing controller.
// Revision : 1.0
// =============================================================================
package ysyx_22050710_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } ctrl_state_e;

    localparam logic [1:0] c_cause_none    = 2'b00;
    localparam logic [1:0] c_cause_ebreak  = 2'b01;
    localparam logic [1:0] c_cause_invalid = 2'b10;
    localparam logic [1:0] c_cause_timeout = 2'b11;

    localparam logic [3:0] c_exctr_ebreak = 4'b1110;

    // ALUctr code points routed to the multi-cycle mul/div unit
    localparam logic [4:0] c_md_lo0 = 5'b01010;
    localparam logic [4:0] c_md_hi0 = 5'b01110;
    localparam logic [4:0] c_md_lo1 = 5'b11001;
    localparam logic [4:0] c_md_hi1 = 5'b11011;

    function automatic logic is_muldiv(input logic [4:0] aluctr);
        return ((aluctr >= c_md_lo0) && (aluctr <= c_md_hi0)) ||
               ((aluctr >= c_md_lo1) && (aluctr <= c_md_hi1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050710_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : ysyx_22050710_ctrl_if
// Brief    : Handshake / decoder / enable bundle between the controller
//            (master) and the rest of the core (slave).
// Revision : 1.0
// =============================================================================
interface ysyx_22050710_ctrl_if;
    logic       o_ifu_req;
    logic       i_ifu_valid;
    logic       o_inst_latch;
    logic       i_is_invalid_inst;
    logic [3:0] i_exctr;
    logic [4:0] i_aluctr;
    logic       i_memre;
    logic       i_memwr;
    logic       o_lsu_req;
    logic       i_lsu_ack;
    logic       o_md_start;
    logic       i_md_done;
    logic       o_pc_we;
    logic       o_reg_we_en;
    logic       o_csr_we_en;
    logic       o_halt;
    logic [1:0] o_halt_cause;
    logic [2:0] o_state;

    modport master (
        output o_ifu_req, o_inst_latch, o_lsu_req, o_md_start,
               o_pc_we, o_reg_we_en, o_csr_we_en, o_halt, o_halt_cause, o_state,
        input  i_ifu_valid, i_is_invalid_inst, i_exctr, i_aluctr,
               i_memre, i_memwr, i_lsu_ack, i_md_done
    );

    modport slave (
        input  o_ifu_req, o_inst_latch, o_lsu_req, o_md_start,
               o_pc_we, o_reg_we_en, o_csr_we_en, o_halt, o_halt_cause, o_state,
        output i_ifu_valid, i_is_invalid_inst, i_exctr, i_aluctr,
               i_memre, i_memwr, i_lsu_ack, i_md_done
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050710_wait_timer.sv
`default_nettype none
// =============================================================================
// Module   : ysyx_22050710_wait_timer
// Brief    : 8-bit handshake wait counter; terminal flag at TIMEOUT-1.
// Revision : 1.0
// =============================================================================
module ysyx_22050710_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  wire  i_clk,
    input  wire  i_rst_n,
    input  wire  i_clear,
    input  wire  i_enable,
    output logic o_terminal
);

    localparam logic [7:0] c_terminal = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_terminal) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_terminal = (r_count == c_terminal);

endmodule
`default_nettype wire

// File: rtl/ysyx_22050710_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : ysyx_22050710_ctrl
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with halt on
//            ebreak, invalid instruction or bus timeout.
//            Mul/div sequencing enabled by YSYX_22050710_MULDIV_EN.
// Revision : 1.0
// =============================================================================
module ysyx_22050710_ctrl
    import ysyx_22050710_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  wire                          i_clk,
    input  wire                          i_rst_n,
    ysyx_22050710_ctrl_if.master         bus
);

    ctrl_state_e r_state;
    ctrl_state_e w_next;
    logic [1:0]  r_cause;
    logic [1:0]  w_next_cause;

    logic w_wait_state;
    logic w_handshake;
    logic w_terminal;
    logic w_is_md;
    logic w_md_start;
    logic w_md_wait;
    logic w_md_illegal;

    assign w_is_md      = is_muldiv(bus.i_aluctr);
    assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_handshake  = (r_state == ST_FETCH) ? bus.i_ifu_valid : bus.i_lsu_ack;

    // Counter is held clear outside FETCH/MEM, so every entry starts at zero
    ysyx_22050710_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (!w_wait_state),
        .i_enable   (w_wait_state && !w_handshake),
        .o_terminal (w_terminal)
    );

`ifdef YSYX_22050710_MULDIV_EN
    logic r_md_started;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_md_started <= 1'b0;
        end else begin
            r_md_started <= (r_state == ST_EXEC);
        end
    end

    assign w_md_start   = (r_state == ST_EXEC) && w_is_md && !r_md_started;
    assign w_md_wait    = w_is_md && !bus.i_md_done;
    assign w_md_illegal = 1'b0;
`else
    logic w_unused_md_done;

    assign w_unused_md_done = bus.i_md_done;
    assign w_md_start       = 1'b0;
    assign w_md_wait        = 1'b0;
    assign w_md_illegal     = w_is_md;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cause <= c_cause_none;
        end else begin
            r_state <= w_next;
            r_cause <= w_next_cause;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_next_cause = r_cause;
        unique case (r_state)
            ST_IDLE: w_next = ST_FETCH;
            ST_FETCH: begin
                if (bus.i_ifu_valid) begin
                    w_next = ST_DECODE;
                end else if (w_terminal) begin
                    w_next       = ST_HALT;
                    w_next_cause = c_cause_timeout;
                end
            end
            ST_DECODE: begin
                if (bus.i_is_invalid_inst) begin
                    w_next       = ST_HALT;
                    w_next_cause = c_cause_invalid;
                end else if (bus.i_exctr == c_exctr_ebreak) begin
                    w_next       = ST_HALT;
                    w_next_cause = c_cause_ebreak;
                end else if (w_md_illegal) begin
                    w_next       = ST_HALT;
                    w_next_cause = c_cause_invalid;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!w_md_wait) begin
                    w_next = (bus.i_memre || bus.i_memwr) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                if (bus.i_lsu_ack) begin
                    w_next = ST_WB;
                end else if (w_terminal) begin
                    w_next       = ST_HALT;
                    w_next_cause = c_cause_timeout;
                end
            end
            ST_WB:   w_next = ST_FETCH;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.o_ifu_req    = (r_state == ST_FETCH);
    assign bus.o_inst_latch = (r_state == ST_FETCH) && bus.i_ifu_valid;
    assign bus.o_lsu_req    = (r_state == ST_MEM);
    assign bus.o_md_start   = w_md_start;
    assign bus.o_pc_we      = (r_state == ST_WB);
    assign bus.o_reg_we_en  = (r_state == ST_WB);
    assign bus.o_csr_we_en  = (r_state == ST_WB);
    assign bus.o_halt       = (r_state == ST_HALT);
    assign bus.o_halt_cause = r_cause;
    assign bus.o_state      = r_state;

endmodule
`default_nettype wire
